// File: rtl/param_stack.sv
// Parametrised LIFO with registered top-of-stack, occupancy count and sticky
// overflow/underflow flags. Simultaneous push+pop replaces the top entry in place.
module param_stack #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic              pop_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_TWO = ADDR_W'(2);

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   sp;
  logic [ADDR_W:0]   sp_nxt;
  logic [ADDR_W-1:0] idx_top;
  logic [ADDR_W-1:0] idx_below;
  logic [DATA_W-1:0] dout_nxt;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              ovf_evt;
  logic              unf_evt;
  op_e               op;

  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == CNT_FULL);

  // Index arithmetic is modulo DEPTH; sp == DEPTH maps its low bits to 0,
  // so sp-1 and sp-2 still land on the correct entries when full.
  assign idx_top   = sp[ADDR_W-1:0] - IDX_ONE;
  assign idx_below = sp[ADDR_W-1:0] - IDX_TWO;

  always_comb begin
    op       = op_e'({push_en, pop_en});
    sp_nxt   = sp;
    dout_nxt = data_out;
    we       = 1'b0;
    waddr    = sp[ADDR_W-1:0];
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          we       = 1'b1;
          waddr    = sp[ADDR_W-1:0];
          sp_nxt   = sp + CNT_ONE;
          dout_nxt = data_in;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_evt = 1'b1;
        end else if (sp == CNT_ONE) begin
          sp_nxt   = '0;
          dout_nxt = '0;
        end else begin
          sp_nxt   = sp - CNT_ONE;
          dout_nxt = mem[idx_below];
        end
      end
      OP_REPLACE: begin
        we       = 1'b1;
        dout_nxt = data_in;
        if (empty) begin
          waddr  = '0;
          sp_nxt = CNT_ONE;
        end else begin
          waddr  = idx_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      data_out  <= dout_nxt;
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[waddr] <= data_in;
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: default 18x16 instance driven with directed
// vectors, 8x4 instance with directed full/overflow plus modelled random traffic.
module tb_param_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_push, a_pop, a_clr;
  logic [17:0] a_din, a_dout;
  logic [4:0]  a_cnt;
  logic        a_empty, a_full, a_ovf, a_unf;

  logic        b_rst, b_push, b_pop, b_clr;
  logic [7:0]  b_din, b_dout;
  logic [2:0]  b_cnt;
  logic        b_empty, b_full, b_ovf, b_unf;

  param_stack #(.DATA_W(18), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(a_rst), .push_en(a_push), .pop_en(a_pop), .data_in(a_din),
    .clr_err(a_clr), .data_out(a_dout), .count(a_cnt), .empty(a_empty),
    .full(a_full), .overflow(a_ovf), .underflow(a_unf));

  param_stack #(.DATA_W(8), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .push_en(b_push), .pop_en(b_pop), .data_in(b_din),
    .clr_err(b_clr), .data_out(b_dout), .count(b_cnt), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf));

  typedef struct {
    string       name;
    logic [17:0] dout;
    logic [4:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_a_t;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  exp_a_t ea;
  exp_b_t eb;
  int checks = 0;
  int errors = 0;

  task automatic step_a(input string name, input bit push, input bit pop,
                        input bit clr, input bit rst, input logic [17:0] din,
                        input logic [17:0] e_dout, input int e_cnt,
                        input bit e_ovf, input bit e_unf);
    exp_a_t x;
    a_push = push; a_pop = pop; a_clr = clr; a_rst = rst; a_din = din;
    @(posedge clk);
    x.name = name; x.dout = e_dout; x.cnt = 5'(e_cnt); x.ovf = e_ovf; x.unf = e_unf;
    qa.push_back(x);
    #1;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_rst = 1'b0;
  endtask

  task automatic step_b(input string name, input bit push, input bit pop,
                        input bit clr, input bit rst, input logic [7:0] din,
                        input logic [7:0] e_dout, input int e_cnt,
                        input bit e_ovf, input bit e_unf);
    exp_b_t x;
    b_push = push; b_pop = pop; b_clr = clr; b_rst = rst; b_din = din;
    @(posedge clk);
    x.name = name; x.dout = e_dout; x.cnt = 3'(e_cnt); x.ovf = e_ovf; x.unf = e_unf;
    qb.push_back(x);
    #1;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      checks++;
      if (a_dout !== ea.dout || a_cnt !== ea.cnt || a_empty !== (ea.cnt == 5'd0) ||
          a_full !== (ea.cnt == 5'd16) || a_ovf !== ea.ovf || a_unf !== ea.unf) begin
        errors++;
        $display("FAIL A %s: got dout=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, want dout=%h cnt=%0d ovf=%b unf=%b",
                 ea.name, a_dout, a_cnt, a_empty, a_full, a_ovf, a_unf,
                 ea.dout, ea.cnt, ea.ovf, ea.unf);
      end
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      checks++;
      if (b_dout !== eb.dout || b_cnt !== eb.cnt || b_empty !== (eb.cnt == 3'd0) ||
          b_full !== (eb.cnt == 3'd4) || b_ovf !== eb.ovf || b_unf !== eb.unf) begin
        errors++;
        $display("FAIL B %s: got dout=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, want dout=%h cnt=%0d ovf=%b unf=%b",
                 eb.name, b_dout, b_cnt, b_empty, b_full, b_ovf, b_unf,
                 eb.dout, eb.cnt, eb.ovf, eb.unf);
      end
    end
  end

  logic [7:0] m[$];
  bit         movf, munf;
  bit         rp, rq, rc;
  int unsigned rr;
  logic [7:0] rd, rexp;

  initial begin
    a_rst = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = '0;
    b_rst = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = '0;

    // ---------------- instance A: directed ----------------
    step_a("reset",      0, 0, 0, 1, 18'h0,     18'h0,     0, 0, 0);
    step_a("push11",     1, 0, 0, 0, 18'h00011, 18'h00011, 1, 0, 0);
    step_a("push22",     1, 0, 0, 0, 18'h00022, 18'h00022, 2, 0, 0);
    step_a("push33",     1, 0, 0, 0, 18'h00033, 18'h00033, 3, 0, 0);
    step_a("idle",       0, 0, 0, 0, 18'h3FFFF, 18'h00033, 3, 0, 0);
    step_a("pop->22",    0, 1, 0, 0, 18'h0,     18'h00022, 2, 0, 0);
    step_a("pop->11",    0, 1, 0, 0, 18'h0,     18'h00011, 1, 0, 0);
    step_a("pop->0",     0, 1, 0, 0, 18'h0,     18'h0,     0, 0, 0);

    for (int i = 1; i <= 16; i++)
      step_a("fill", 1, 0, 0, 0, 18'(i), 18'(i), i, 0, 0);
    step_a("push_full",  1, 0, 0, 0, 18'h3FFFF, 18'h00010, 16, 1, 0);
    for (int i = 15; i >= 1; i--)
      step_a("drain", 0, 1, 0, 0, 18'h0, 18'(i), i, 1, 0);
    step_a("drain_last", 0, 1, 0, 0, 18'h0,     18'h0,     0, 1, 0);
    step_a("clr_ovf",    0, 0, 1, 0, 18'h0,     18'h0,     0, 0, 0);

    step_a("pop_empty",  0, 1, 0, 0, 18'h0,     18'h0,     0, 0, 1);
    step_a("clr_unf",    0, 0, 1, 0, 18'h0,     18'h0,     0, 0, 0);
    step_a("pop_empty2", 0, 1, 0, 0, 18'h0,     18'h0,     0, 0, 1);
    step_a("clr+pop",    0, 1, 1, 0, 18'h0,     18'h0,     0, 0, 1);
    step_a("clr_unf2",   0, 0, 1, 0, 18'h0,     18'h0,     0, 0, 0);

    step_a("push5",      1, 0, 0, 0, 18'h00005, 18'h00005, 1, 0, 0);
    step_a("push7",      1, 0, 0, 0, 18'h00007, 18'h00007, 2, 0, 0);
    step_a("replace",    1, 1, 0, 0, 18'h2AAAA, 18'h2AAAA, 2, 0, 0);
    step_a("pop->5",     0, 1, 0, 0, 18'h0,     18'h00005, 1, 0, 0);
    step_a("pop->0b",    0, 1, 0, 0, 18'h0,     18'h0,     0, 0, 0);
    step_a("repl_empty", 1, 1, 0, 0, 18'h00009, 18'h00009, 1, 0, 0);
    step_a("pop->0c",    0, 1, 0, 0, 18'h0,     18'h0,     0, 0, 0);
    for (int i = 1; i <= 16; i++)
      step_a("fill2", 1, 0, 0, 0, 18'(i), 18'(i), i, 0, 0);
    step_a("repl_full",  1, 1, 0, 0, 18'h12345, 18'h12345, 16, 0, 0);
    step_a("pop->f",     0, 1, 0, 0, 18'h0,     18'h0000F, 15, 0, 0);
    step_a("repl_chk",   0, 1, 0, 0, 18'h0,     18'h0000E, 14, 0, 0);

    step_a("reset2",     0, 0, 0, 1, 18'h0,     18'h0,     0, 0, 0);
    step_a("pop_empty3", 0, 1, 0, 0, 18'h0,     18'h0,     0, 0, 1);
    step_a("pushA",      1, 0, 0, 0, 18'h0000A, 18'h0000A, 1, 0, 1);
    step_a("pushB",      1, 0, 0, 0, 18'h0000B, 18'h0000B, 2, 0, 1);
    step_a("pushC",      1, 0, 0, 0, 18'h0000C, 18'h0000C, 3, 0, 1);
    step_a("rst+push",   1, 0, 0, 1, 18'h00077, 18'h0,     0, 0, 0);
    step_a("push1",      1, 0, 0, 0, 18'h00001, 18'h00001, 1, 0, 0);
    step_a("idle2",      0, 0, 0, 0, 18'h0,     18'h00001, 1, 0, 0);

    // ---------------- instance B: small geometry ----------------
    step_b("reset",      0, 0, 0, 1, 8'h0, 8'h0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      step_b("fill", 1, 0, 0, 0, 8'(i), 8'(i), i, 0, 0);
    step_b("push_full",  1, 0, 0, 0, 8'h55, 8'h04, 4, 1, 0);
    step_b("reset2",     0, 0, 0, 1, 8'h0, 8'h0, 0, 0, 0);

    movf = 1'b0; munf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rr = $urandom_range(0, 99);
      rp = (rr < 45) || (rr >= 80 && rr < 92);
      rq = (rr >= 45 && rr < 92);
      rc = ($urandom_range(0, 15) == 0);
      rd = 8'($urandom);
      if (rc) begin
        movf = 1'b0;
        munf = 1'b0;
      end
      if (rp && rq) begin
        if (m.size() > 0) m[m.size()-1] = rd;
        else m.push_back(rd);
      end else if (rp) begin
        if (m.size() < 4) m.push_back(rd);
        else movf = 1'b1;
      end else if (rq) begin
        if (m.size() > 0) void'(m.pop_back());
        else munf = 1'b1;
      end
      rexp = (m.size() > 0) ? m[m.size()-1] : 8'h0;
      step_b("random", rp, rq, rc, 0, rd, rexp, m.size(), movf, munf);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: scoreboard left %0d/%0d entries, want 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
